// File: rtl/note_recorder_pkg.sv
// note_recorder_pkg: note codes, pitch indices and recorder states shared by the recorder and the player
package note_recorder_pkg;
   localparam int SLOT_W = 6;
   localparam logic [SLOT_W-1:0] NOTE_REST = 6'b000000;
   localparam int NOTE_VALID_BIT = 3;
   localparam int OCTAVE_LO_BIT = 4;
   localparam logic [2:0] DO = 3'd0;
   localparam logic [2:0] RE = 3'd1;
   localparam logic [2:0] MI = 3'd2;
   localparam logic [2:0] FA = 3'd3;
   localparam logic [2:0] SOL = 3'd4;
   localparam logic [2:0] LA = 3'd5;
   localparam logic [2:0] SI = 3'd6;
   typedef enum logic [1:0] {IDLE, ARM, REC, DONE} rec_state_t;
   // Lowest key index wins; no key pressed gives a rest.
   function automatic logic [SLOT_W-1:0] note_code(input logic [6:0] keys, input logic lo);
      note_code = NOTE_REST;
      for (int i = int'(SI); i >= int'(DO); i--)
         if (keys[i]) begin
            note_code = NOTE_REST;
            note_code[NOTE_VALID_BIT] = 1'b1;
            note_code[OCTAVE_LO_BIT] = lo;
            note_code[2:0] = 3'(i);
         end
   endfunction
endpackage

// File: rtl/note_recorder_key_debounce.sv
// key_debounce: 2-FF synchroniser plus stability counter; output follows input after DEBOUNCE_CYCLES steady cycles
module key_debounce #(
   parameter int W = 8,
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [W-1:0] s1, s2, cand;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         cand <= '0;
         cnt <= '0;
         stable <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         cand <= s2;
         if (s2 != cand || s2 == stable) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/note_recorder.sv
// note_recorder: quantises live key presses into sixteenth-note slots of a packed melody bus
module note_recorder
   import note_recorder_pkg::*;
#(
   parameter int TICK_CYCLES = 12_500_000,
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int DEPTH = 64,
   parameter int ADDR_W = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [6:0]                key,
   input  logic                      octave_lo,
   input  logic                      rec_en,
   output logic [DEPTH*SLOT_W-1:0]   melody,
   output logic [ADDR_W:0]           length,
   output logic                      recording,
   output logic                      full,
   output logic                      done
);
   localparam int TW = $clog2(TICK_CYCLES + 1);
   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);
   rec_state_t state, state_n;
   logic [7:0] db;
   logic [SLOT_W-1:0] code;
   logic r1, rec_s, rec_q, rise, fall;
   logic [TW-1:0] tick_cnt;
   logic [ADDR_W:0] last_len, last_len_n, new_len, len_n;
   logic tc, wr, clear;

   key_debounce #(.W(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .raw({key, octave_lo}), .stable(db)
   );

   assign code = note_code(db[7:1], db[0]);
   assign rise = rec_s & ~rec_q;
   assign fall = ~rec_s & rec_q;
   assign recording = state == ARM || state == REC;

   always_comb begin
      tc = tick_cnt == TW'(TICK_CYCLES - 1);
      wr = state == REC && tc;
      new_len = length + 1'b1;
      last_len_n = (wr && code != NOTE_REST) ? new_len : last_len;
      // A stop on the terminal tick still keeps that slot before trimming.
      len_n = fall ? last_len_n : wr ? new_len : length;
      clear = rise && (state == IDLE || state == DONE);
      state_n = state;
      case (state)
         IDLE, DONE: if (rise) state_n = ARM;
         ARM: state_n = fall ? DONE : code != NOTE_REST ? REC : ARM;
         REC: if (fall || len_n == FULL_LEN) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1 <= 1'b0;
         rec_s <= 1'b0;
         rec_q <= 1'b0;
         done <= 1'b0;
         tick_cnt <= '0;
         melody <= '0;
         length <= '0;
         full <= 1'b0;
         last_len <= '0;
      end else begin
         r1 <= rec_en;
         rec_s <= r1;
         rec_q <= rec_s;
         done <= state_n == DONE && state != DONE;
         tick_cnt <= (state == REC && !tc) ? tick_cnt + 1'b1 : '0;
         if (clear) begin
            melody <= '0;
            length <= '0;
            full <= 1'b0;
            last_len <= '0;
         end else if (state == REC) begin
            for (int i = 0; i < DEPTH; i++)
               if (wr && length[ADDR_W-1:0] == ADDR_W'(i)) melody[i*SLOT_W +: SLOT_W] <= code;
            length <= len_n;
            full <= len_n == FULL_LEN;
            last_len <= last_len_n;
         end
      end
   end
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed sessions; expected results queued per session and checked on each done pulse
module tb_note_recorder;
   localparam int DEPTH = 8;
   localparam logic [5:0] C_DO = 6'b001000;
   localparam logic [5:0] C_MI = 6'b001010;
   localparam logic [5:0] C_FA = 6'b001011;
   localparam logic [5:0] C_SOL = 6'b001100;
   localparam logic [5:0] C_SI = 6'b001110;
   localparam logic [5:0] C_LRE = 6'b011001;

   typedef struct {
      logic [3:0]  len;
      logic        full;
      logic [47:0] mel;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, octave_lo = 1'b0, rec_en = 1'b0;
   logic [6:0] key = '0;
   logic [47:0] melody;
   logic [3:0] length;
   logic recording, full, done;
   int total = 0, bad = 0;
   exp_t q[$];

   note_recorder #(.TICK_CYCLES(10), .DEBOUNCE_CYCLES(3), .DEPTH(DEPTH), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .key(key), .octave_lo(octave_lo), .rec_en(rec_en),
      .melody(melody), .length(length), .recording(recording), .full(full), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_done(input logic [3:0] len, input logic f, input logic [47:0] mel);
      exp_t e;
      e.len = len;
      e.full = f;
      e.mel = mel;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("done_length", 64'(length), 64'(e.len));
            chk("done_full", 64'(full), 64'(e.full));
            chk("done_melody", 64'(melody), 64'(e.mel));
            chk("done_recording", 64'(recording), 64'd0);
         end
      end
   end

   initial begin
      cyc(3);
      chk("rst_melody", 64'(melody), 64'd0);
      chk("rst_length", 64'(length), 64'd0);
      chk("rst_recording", 64'(recording), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      cyc(5);
      // basic capture: do held 35 cycles, sol 20 cycles
      expect_done(4'd5, 1'b0, {18'd0, C_SOL, C_SOL, C_DO, C_DO, C_DO});
      rec_en = 1'b1;
      key = 7'h01;
      cyc(35);
      key = 7'h10;
      cyc(20);
      key = '0;
      rec_en = 1'b0;
      cyc(20);
      // leading silence stays in ARM
      rec_en = 1'b1;
      cyc(100);
      chk("arm_recording", 64'(recording), 64'd1);
      chk("arm_length", 64'(length), 64'd0);
      chk("arm_full", 64'(full), 64'd0);
      expect_done(4'd1, 1'b0, {42'd0, C_MI});
      key = 7'h04;
      cyc(15);
      key = '0;
      cyc(15);
      rec_en = 1'b0;
      cyc(20);
      // trailing rests trimmed
      expect_done(4'd2, 1'b0, {36'd0, C_FA, C_FA});
      rec_en = 1'b1;
      key = 7'h08;
      cyc(25);
      key = '0;
      cyc(30);
      rec_en = 1'b0;
      cyc(20);
      // fill every slot
      expect_done(4'd8, 1'b1, {8{C_SI}});
      rec_en = 1'b1;
      key = 7'h40;
      cyc(100);
      key = '0;
      rec_en = 1'b0;
      cyc(20);
      chk("full_hold_length", 64'(length), 64'd8);
      chk("full_hold_full", 64'(full), 64'd1);
      chk("full_hold_melody", 64'(melody), 64'({8{C_SI}}));
      // priority re over fa in low octave, then a la glitch
      expect_done(4'd1, 1'b0, {42'd0, C_LRE});
      rec_en = 1'b1;
      octave_lo = 1'b1;
      key = 7'b0001010;
      cyc(15);
      key = '0;
      cyc(6);
      key = 7'h20;
      cyc(2);
      key = '0;
      cyc(7);
      rec_en = 1'b0;
      cyc(20);
      octave_lo = 1'b0;
      cyc(20);
      // reset in the middle of a recording
      rec_en = 1'b1;
      key = 7'h01;
      cyc(25);
      chk("midrec_length", 64'(length), 64'd1);
      rst_n = 1'b0;
      cyc(2);
      chk("midrst_melody", 64'(melody), 64'd0);
      chk("midrst_length", 64'(length), 64'd0);
      chk("midrst_recording", 64'(recording), 64'd0);
      chk("midrst_full", 64'(full), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      key = '0;
      rec_en = 1'b0;
      rst_n = 1'b1;
      cyc(20);
      chk("pending_sessions", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
